// File: rtl/anton_neopixel_decoder_pkg.sv
// Shared types, default timing and width helpers for the NeoPixel receive decoder.
package anton_neopixel_decoder_pkg;

    typedef enum logic [1:0] {
        DEC_SYNC = 2'd0,
        DEC_IDLE = 2'd1,
        DEC_HIGH = 2'd2,
        DEC_LOW  = 2'd3
    } decState_t;

    localparam int BUFFER_END_DEFAULT   = 63;
    localparam int SLOT_CYCLES_DEFAULT  = 4;
    localparam int RESET_CYCLES_DEFAULT = 256;

    // A bit is 8 slots: a 0 is high for ~2 slots, a 1 for ~5; 3.5 slots splits them.
    function automatic int oneThreshold(int slotCycles);
        return (7 * slotCycles) / 2;
    endfunction

    function automatic int idxWidth(int lastIdx);
        return (lastIdx < 1) ? 1 : $clog2(lastIdx + 1);
    endfunction

    function automatic int cntWidth(int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/anton_neopixel_decoder_if.sv
// Decoded byte stream with position and frame/error strobes.
interface anton_neopixel_decoder_if
    import anton_neopixel_decoder_pkg::*;
#(
    parameter int BUFFER_END = BUFFER_END_DEFAULT
);
    localparam int IDX_W = idxWidth(BUFFER_END);

    logic [7:0]       byteData;
    logic             byteValid;
    logic [1:0]       channelIndex;
    logic [IDX_W-1:0] byteIndex;
    logic             frameDone;
    logic             errGlitch;
    logic             errPartial;
    logic             errOverflow;

    modport master (
        output byteData, byteValid, channelIndex, byteIndex,
        output frameDone, errGlitch, errPartial, errOverflow
    );

    modport slave (
        input byteData, byteValid, channelIndex, byteIndex,
        input frameDone, errGlitch, errPartial, errOverflow
    );

endinterface

// File: rtl/anton_neopixel_sync.sv
// Two-flop synchronizer for the serial line with registered rise/fall pulses.
module anton_neopixel_sync (
    input  logic clk,
    input  logic rstn,
    input  logic neoData,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta;
    logic syncQ;
    logic syncD;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta  <= 1'b0;
            syncQ <= 1'b0;
            syncD <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= neoData;
            syncQ <= meta;
            syncD <= syncQ;
            rise  <= syncQ & ~syncD;
            fall  <= ~syncQ & syncD;
        end
    end

    assign level = syncQ;

endmodule

// File: rtl/anton_neopixel_decoder.sv
// WS2812-style receive decoder: pulse-width bit recovery, MSB-first byte assembly, gap framing.
//   state     | meaning
//   DEC_SYNC  | waiting for a full low gap before trusting the line
//   DEC_IDLE  | gap seen, waiting for the first high pulse of a frame
//   DEC_HIGH  | measuring a high pulse
//   DEC_LOW   | between bits, watching for the next pulse or the frame gap
module anton_neopixel_decoder
    import anton_neopixel_decoder_pkg::*;
#(
    parameter int BUFFER_END    = BUFFER_END_DEFAULT,
    parameter int SLOT_CYCLES   = SLOT_CYCLES_DEFAULT,
    parameter int ONE_THRESHOLD = oneThreshold(SLOT_CYCLES),
    parameter int MIN_HIGH      = SLOT_CYCLES,
    parameter int MAX_HIGH      = 7 * SLOT_CYCLES,
    parameter int RESET_CYCLES  = RESET_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic neoData,
    input  logic enable,
    anton_neopixel_decoder_if.master bus
);
    localparam int IDX_W  = idxWidth(BUFFER_END);
    localparam int HIGH_W = cntWidth(MAX_HIGH + 1);
    localparam int LOW_W  = cntWidth(RESET_CYCLES);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BUFFER_END);
    localparam logic [HIGH_W-1:0] HIGH_MIN = HIGH_W'(MIN_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(MAX_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_ONE = HIGH_W'(ONE_THRESHOLD);
    localparam logic [LOW_W-1:0]  LOW_GAP  = LOW_W'(RESET_CYCLES);

    logic lineLevel;
    logic lineRise;
    logic lineFall;

    anton_neopixel_sync uSync (
        .clk     (clk),
        .rstn    (rstn),
        .neoData (neoData),
        .level   (lineLevel),
        .rise    (lineRise),
        .fall    (lineFall)
    );

    decState_t         state;
    logic [2:0]        bitCnt;
    logic [HIGH_W-1:0] highCnt;
    logic [LOW_W-1:0]  lowCnt;
    logic [6:0]        shiftReg;
    logic [7:0]        byteDataR;
    logic              byteValidR;
    logic [1:0]        channelIdx;
    logic [IDX_W-1:0]  byteIdx;
    logic              indexFull;
    logic              frameDoneR;
    logic              errGlitchR;
    logic              errPartialR;
    logic              errOverflowR;
    logic              bitVal;

    assign bitVal = (highCnt >= HIGH_ONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= DEC_SYNC;
            bitCnt       <= '0;
            highCnt      <= '0;
            lowCnt       <= '0;
            shiftReg     <= '0;
            byteDataR    <= '0;
            byteValidR   <= 1'b0;
            channelIdx   <= '0;
            byteIdx      <= '0;
            indexFull    <= 1'b0;
            frameDoneR   <= 1'b0;
            errGlitchR   <= 1'b0;
            errPartialR  <= 1'b0;
            errOverflowR <= 1'b0;
        end else begin
            byteValidR   <= 1'b0;
            frameDoneR   <= 1'b0;
            errGlitchR   <= 1'b0;
            errPartialR  <= 1'b0;
            errOverflowR <= 1'b0;

            // Position advances the cycle after the strobe so the strobe shows the byte's own slot.
            if (byteValidR) begin
                channelIdx <= (channelIdx == 2'd2) ? 2'd0 : channelIdx + 2'd1;
                if (byteIdx == IDX_LAST) indexFull <= 1'b1;
                else                     byteIdx   <= byteIdx + 1'b1;
            end

            if (!enable) begin
                state      <= DEC_SYNC;
                bitCnt     <= '0;
                highCnt    <= '0;
                lowCnt     <= '0;
                channelIdx <= '0;
                byteIdx    <= '0;
                indexFull  <= 1'b0;
            end else begin
                case (state)
                    DEC_SYNC: begin
                        if (lineLevel) begin
                            lowCnt <= '0;
                        end else if (lowCnt == LOW_GAP) begin
                            lowCnt <= '0;
                            state  <= DEC_IDLE;
                        end else begin
                            lowCnt <= lowCnt + 1'b1;
                        end
                    end
                    DEC_IDLE: begin
                        if (lineRise) begin
                            highCnt <= HIGH_W'(1);
                            state   <= DEC_HIGH;
                        end
                    end
                    DEC_HIGH: begin
                        if ((highCnt > HIGH_MAX) || (lineFall && (highCnt < HIGH_MIN))) begin
                            errGlitchR <= 1'b1;
                            state      <= DEC_SYNC;
                            bitCnt     <= '0;
                            highCnt    <= '0;
                            lowCnt     <= '0;
                            channelIdx <= '0;
                            byteIdx    <= '0;
                            indexFull  <= 1'b0;
                        end else if (lineFall) begin
                            shiftReg <= {shiftReg[5:0], bitVal};
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                byteDataR    <= {shiftReg, bitVal};
                                byteValidR   <= 1'b1;
                                errOverflowR <= indexFull;
                            end
                            lowCnt <= LOW_W'(1);
                            state  <= DEC_LOW;
                        end else begin
                            highCnt <= highCnt + 1'b1;
                        end
                    end
                    DEC_LOW: begin
                        // The gap check wins over a coincident rising edge.
                        if (lowCnt == LOW_GAP) begin
                            frameDoneR  <= 1'b1;
                            errPartialR <= (bitCnt != 3'd0);
                            bitCnt      <= '0;
                            lowCnt      <= '0;
                            channelIdx  <= '0;
                            byteIdx     <= '0;
                            indexFull   <= 1'b0;
                            state       <= DEC_IDLE;
                        end else if (lineRise) begin
                            highCnt <= HIGH_W'(1);
                            state   <= DEC_HIGH;
                        end else begin
                            lowCnt <= lowCnt + 1'b1;
                        end
                    end
                    default: state <= DEC_SYNC;
                endcase
            end
        end
    end

    assign bus.byteData     = byteDataR;
    assign bus.byteValid    = byteValidR;
    assign bus.channelIndex = channelIdx;
    assign bus.byteIndex    = byteIdx;
    assign bus.frameDone    = frameDoneR;
    assign bus.errGlitch    = errGlitchR;
    assign bus.errPartial   = errPartialR;
    assign bus.errOverflow  = errOverflowR;

endmodule
